// File: rtl/polyadd_ctrl.sv
// Pointwise modular add/sub sequencer: C[k] = (A[k] +/- B[k]) mod Q for k = 0..len-1.
// Latency: RD_LAT+1 cycles from read strobe to write strobe; one coefficient per cycle sustained.
// Backpressure: none; banks must accept one read and one write per cycle, start is only taken in IDLE.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   i_start/i_sub/i_len  job request; sub-select and length are latched when start is accepted
//   o_busy/o_done        busy from accepted start through the last write, done pulses one cycle after it
//   o_rd_en/o_rd_addr    shared read strobe/address to the A and B banks
//   i_rd_a/i_rd_b        bank read data, valid RD_LAT cycles after o_rd_en
//   o_wr_en/o_wr_addr/o_wr_data  write port to the C bank
module polyadd_ctrl #(
    parameter int COE_WIDTH = 39,
    parameter int Q_TYPE    = 0,
    parameter int LOG_N     = 12,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_sub,
    input  logic [LOG_N:0]       i_len,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_rd_en,
    output logic [LOG_N-1:0]     o_rd_addr,
    input  logic [COE_WIDTH-1:0] i_rd_a,
    input  logic [COE_WIDTH-1:0] i_rd_b,
    output logic                 o_wr_en,
    output logic [LOG_N-1:0]     o_wr_addr,
    output logic [COE_WIDTH-1:0] o_wr_data
);

    // Residue-domain moduli selectable by Q_TYPE.
    localparam logic [63:0] Q0_C  = 64'd549755809793;
    localparam logic [63:0] Q1_C  = 64'd549755797505;
    localparam logic [63:0] Q2_C  = 64'd274877890561;
    localparam logic [63:0] Q_SEL = (Q_TYPE == 1) ? Q1_C : ((Q_TYPE == 2) ? Q2_C : Q0_C);
    localparam logic [COE_WIDTH-1:0] Q = Q_SEL[COE_WIDTH-1:0];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              r_state;
    logic                    r_sub;
    logic [LOG_N:0]          r_len;
    // One bit wider than the address so a full 2^LOG_N job does not wrap early.
    logic [LOG_N:0]          r_rd_cnt;
    logic [LOG_N:0]          r_wr_cnt;

    logic [RD_LAT-1:0]            r_vld_sr;
    logic [RD_LAT-1:0][LOG_N-1:0] r_addr_sr;

    logic                    r_wr_en;
    logic [LOG_N-1:0]        r_wr_addr;
    logic [COE_WIDTH-1:0]    r_wr_data;

    logic [LOG_N:0]          w_wr_cnt_nxt;
    logic                    w_rd_last;
    logic [COE_WIDTH-1:0]    w_b_eff;
    logic [COE_WIDTH:0]      w_sum;
    logic                    w_ge_q;
    logic [COE_WIDTH-1:0]    w_res;

    assign o_busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done    = (r_state == S_DONE);
    assign o_rd_en   = (r_state == S_RUN);
    assign o_rd_addr = r_rd_cnt[LOG_N-1:0];
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;

    // Look ahead one write so DONE lands the cycle right after the last write.
    assign w_wr_cnt_nxt = r_wr_cnt + {{LOG_N{1'b0}}, r_wr_en};
    assign w_rd_last    = (r_rd_cnt == (r_len - 1'b1));

    // Subtraction as addition of the negated operand; -0 stays 0 so the sum is < 2Q.
    assign w_b_eff = r_sub ? ((i_rd_b == '0) ? '0 : (Q - i_rd_b)) : i_rd_b;
    assign w_sum   = {1'b0, i_rd_a} + {1'b0, w_b_eff};
    assign w_ge_q  = (w_sum >= {1'b0, Q});
    // When sum >= Q the true difference fits in COE_WIDTH bits, so the low bits suffice.
    assign w_res   = w_ge_q ? (w_sum[COE_WIDTH-1:0] - Q) : w_sum[COE_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sub    <= 1'b0;
            r_len    <= '0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sub    <= i_sub;
                        r_len    <= i_len;
                        r_rd_cnt <= '0;
                        r_wr_cnt <= '0;
                        // An empty job skips the reads but still spends one busy
                        // cycle in DRAIN, where the zero write count completes it.
                        r_state  <= (i_len == '0) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                    r_wr_cnt <= w_wr_cnt_nxt;
                    if (w_rd_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_wr_cnt <= w_wr_cnt_nxt;
                    if (w_wr_cnt_nxt == r_len) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Valid/address travel alongside the bank access so they meet the returned data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_sr  <= '0;
            r_addr_sr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_vld_sr[0]  <= o_rd_en;
            r_addr_sr[0] <= o_rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_sr[i]  <= r_vld_sr[i-1];
                r_addr_sr[i] <= r_addr_sr[i-1];
            end
            r_wr_en <= r_vld_sr[RD_LAT-1];
            if (r_vld_sr[RD_LAT-1]) begin
                r_wr_addr <= r_addr_sr[RD_LAT-1];
                r_wr_data <= w_res;
            end
        end
    end

endmodule
